alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//   Reservation station feeding the ALU in the Tomasulo core (the initiator side of the ALU
//   alu_input/arith_type/r1_val/r2_val/inst_rob_id interface). Buffers issued arithmetic and
//   branch ops and tracks operands still pending on a ROB tag. Wakes operands from the ALU and
//   LSB result broadcasts, and dispatches at most one ready entry per cycle to the ALU.
// PARAMETERS
//   RS_SIZE_BIT   3  log2 of entry count (8 entries)
//   ROB_SIZE_BIT  4  ROB tag width
//   RS_TYPE_BIT   5  op encoding {is_branch, func3, func7b}, passed to ALU unchanged
// PORTS
//   clk_in        in   1   clock
//   rst_in        in   1   reset, asynchronous, active-high
//   rdy_in        in   1   global ready; when low, all state and outputs hold
//   clear         in   1   flush on mispredict
//   issue_valid   in   1   issue request this cycle
//   issue_type    in   RS_TYPE_BIT   op type
//   issue_r1_val  in   32  src1 value; valid only when issue_r1_dep=0
//   issue_r1_dep  in   1   src1 waits on ROB tag issue_r1_rob
//   issue_r1_rob  in   ROB_SIZE_BIT  src1 producer tag
//   issue_r2_val / issue_r2_dep / issue_r2_rob   same as src1, for src2
//   issue_rob_id  in   ROB_SIZE_BIT  destination ROB tag
//   rs_full       out  1   combinational; high when no entry is free
//   alu_fi, alu_rob_id, alu_res   in  1/ROB_SIZE_BIT/32  ALU result broadcast
//   lsb_fi, lsb_rob_id, lsb_res   in  1/ROB_SIZE_BIT/32  LSB result broadcast
//   alu_input     out  1   registered; dispatch valid, one cycle per op
//   arith_type    out  RS_TYPE_BIT   dispatched op type
//   r1_val, r2_val out 32  dispatched operands
//   inst_rob_id   out  ROB_SIZE_BIT  dispatched tag; 0 when alu_input=0
// BEHAVIOUR
//   - Reset: all entries not busy; alu_input=0, arith_type=0, r1_val=0, r2_val=0,
//     inst_rob_id=0.
//   - Entry fields: busy, type, v1, dep1, q1, v2, dep2, q2, rob.
//   - Issue (issue_valid and !rs_full): write the lowest-index non-busy entry, with busy=1.
//     * If issue_r1_dep=1 and a broadcast in the same cycle matches issue_r1_rob:
//       capture that broadcast value, with dep1=0. Same rule for src2.
//     * If both the ALU and LSB broadcasts match, they carry the same tag; the ALU value is used.
//   - Issue while rs_full: request dropped; no state change.
//   - Wake-up: every busy entry with depX=1 and qX equal to a valid broadcast tag latches the
//     value and clears depX at that edge.
//   - Dispatch: select the lowest-index busy entry with dep1=0 and dep2=0, using state
//     registered before this edge. Values captured by a wake-up are usable the next cycle.
//     * At the edge: alu_input<=1, drive type/v1/v2/rob, and clear the entry's busy bit.
//     * With no candidate: alu_input<=0 and inst_rob_id<=0; arith_type/r1_val/r2_val hold.
//   - Latency: an op issued ready at edge N becomes resident, dispatches at edge N+1
//     (alu_input high during cycle N+1), and its ALU result arrives at edge N+2.
//   - Slot reuse: free-slot selection uses pre-edge busy bits. A slot dispatched at edge N
//     accepts issue from edge N+1 on. Issue and dispatch never target the same slot in one edge.
//   - rs_full: derived from current busy bits only; it does not anticipate same-cycle dispatch.
//   - clear (synchronous, when rdy_in=1): all busy<=0, alu_input<=0, inst_rob_id<=0.
//     clear has priority over issue, wake-up and dispatch in the same cycle.
//   - rdy_in=0: no issue, wake-up or dispatch. Broadcasts in that cycle are ignored; the
//     producers stall too.
//   - rst_in asserted mid-operation: immediate return to reset state; in-flight entries lost.
// TESTING
//   1. Issue ADD r1=5,r2=7 (no deps), rob=3 -> next cycle alu_input=1, arith_type=00000,
//      r1_val=5, r2_val=7, inst_rob_id=3; following cycle alu_input=0.
//   2. Issue SUB with src1 dep on rob 2; alu_fi=1, alu_rob_id=2, alu_res=0x10 two cycles later
//      -> dispatch one cycle after the broadcast with r1_val=0x10.
//   3. Issue with dep on rob 6 in the same cycle that lsb_fi=1, lsb_rob_id=6, lsb_res=9
//      -> captured at issue; dispatched next cycle with value 9.
//   4. Issue 8 entries all dependent on rob 1 -> rs_full=1; a 9th issue is dropped.
//      Broadcast rob 1 -> 8 dispatches on consecutive cycles in index order; rs_full drops after
//      the first dispatch.
//   5. 4 ready entries resident; clear=1 -> next cycle alu_input=0 and rs_full=0; no further
//      dispatch.
//   6. Hold rdy_in=0 for 3 cycles with a ready entry -> alu_input holds; dispatch resumes the
//      cycle after rdy_in=1. Assert rst_in mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: reservation station in front of the ALU.
// Holds up to 2**RS_SIZE_BIT arithmetic/branch ops, wakes pending operands from
// the ALU and LSB result broadcasts, and dispatches the lowest-index ready entry
// to the ALU (at most one per cycle) through registered outputs.
module alu_rs #(
  parameter int RS_SIZE_BIT  = 3,
  parameter int ROB_SIZE_BIT = 4,
  parameter int RS_TYPE_BIT  = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear,
  // issue side
  input  logic                    issue_valid,
  input  logic [RS_TYPE_BIT-1:0]  issue_type,
  input  logic [31:0]             issue_r1_val,
  input  logic                    issue_r1_dep,
  input  logic [ROB_SIZE_BIT-1:0] issue_r1_rob,
  input  logic [31:0]             issue_r2_val,
  input  logic                    issue_r2_dep,
  input  logic [ROB_SIZE_BIT-1:0] issue_r2_rob,
  input  logic [ROB_SIZE_BIT-1:0] issue_rob_id,
  output logic                    rs_full,
  // result broadcasts
  input  logic                    alu_fi,
  input  logic [ROB_SIZE_BIT-1:0] alu_rob_id,
  input  logic [31:0]             alu_res,
  input  logic                    lsb_fi,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
  input  logic [31:0]             lsb_res,
  // dispatch to ALU
  output logic                    alu_input,
  output logic [RS_TYPE_BIT-1:0]  arith_type,
  output logic [31:0]             r1_val,
  output logic [31:0]             r2_val,
  output logic [ROB_SIZE_BIT-1:0] inst_rob_id
);

  localparam int RS_SIZE = 1 << RS_SIZE_BIT;

  typedef struct packed {
    logic [RS_TYPE_BIT-1:0]  op;
    logic [31:0]             v1;
    logic                    dep1;
    logic [ROB_SIZE_BIT-1:0] q1;
    logic [31:0]             v2;
    logic                    dep2;
    logic [ROB_SIZE_BIT-1:0] q2;
    logic [ROB_SIZE_BIT-1:0] rob;
  } entry_t;

  logic [RS_SIZE-1:0]     busy;
  entry_t                 ent [RS_SIZE];

  logic                   free_found;
  logic [RS_SIZE_BIT-1:0] free_idx;
  logic                   ready_found;
  logic [RS_SIZE_BIT-1:0] ready_idx;
  logic                   issue_fire;

  // Resolve one operand against this cycle's broadcasts; returns {dep, value}.
  // The ALU broadcast wins when both match (they then carry the same tag).
  function automatic logic [32:0] wake(input logic dep,
                                       input logic [ROB_SIZE_BIT-1:0] q,
                                       input logic [31:0] v);
    logic [32:0] r;
    r = {dep, v};
    if (dep && lsb_fi && (lsb_rob_id == q)) r = {1'b0, lsb_res};
    if (dep && alu_fi && (alu_rob_id == q)) r = {1'b0, alu_res};
    return r;
  endfunction

  // Lowest-index free slot and lowest-index ready entry, from pre-edge state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = i[RS_SIZE_BIT-1:0];
      end
      if (busy[i] && !ent[i].dep1 && !ent[i].dep2) begin
        ready_found = 1'b1;
        ready_idx   = i[RS_SIZE_BIT-1:0];
      end
    end
  end

  assign rs_full    = ~free_found;
  assign issue_fire = issue_valid && free_found;

  // Occupancy and registered dispatch outputs; clear overrides issue and dispatch.
  always_ff @(posedge clk_in or posedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_in) begin
      busy        <= '0;
      alu_input   <= 1'b0;
      arith_type  <= '0;
      r1_val      <= '0;
      r2_val      <= '0;
      inst_rob_id <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        busy        <= '0;
        alu_input   <= 1'b0;
        inst_rob_id <= '0;
      end else begin
        if (ready_found) begin
          busy[ready_idx] <= 1'b0;
          alu_input       <= 1'b1;
          arith_type      <= ent[ready_idx].op;
          r1_val          <= ent[ready_idx].v1;
          r2_val          <= ent[ready_idx].v2;
          inst_rob_id     <= ent[ready_idx].rob;
        end else begin
          alu_input   <= 1'b0;
          inst_rob_id <= '0;
        end
        // The free slot is never busy, so it never collides with the dispatched slot.
        if (issue_fire) busy[free_idx] <= 1'b1;
      end
    end
  end

  // Entry payload: wake-up of pending operands, then the issue write into the free slot.
  always_ff @(posedge clk_in) begin
    // NOTE: the payload array has no reset; busy gates every use, so stale contents are harmless.
    if (rdy_in && !clear) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        {ent[i].dep1, ent[i].v1} <= wake(ent[i].dep1, ent[i].q1, ent[i].v1);
        {ent[i].dep2, ent[i].v2} <= wake(ent[i].dep2, ent[i].q2, ent[i].v2);
      end
      if (issue_fire) begin
        ent[free_idx].op  <= issue_type;
        ent[free_idx].q1  <= issue_r1_rob;
        ent[free_idx].q2  <= issue_r2_rob;
        ent[free_idx].rob <= issue_rob_id;
        {ent[free_idx].dep1, ent[free_idx].v1} <= wake(issue_r1_dep, issue_r1_rob, issue_r1_val);
        {ent[free_idx].dep2, ent[free_idx].v2} <= wake(issue_r2_dep, issue_r2_rob, issue_r2_val);
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scoreboard bench for alu_rs. Stimulus pushes the expected
// dispatch into a queue; a monitor pops and compares on every new dispatch.
module tb_alu_rs;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear;
  logic        issue_valid;
  logic [4:0]  issue_type;
  logic [31:0] issue_r1_val, issue_r2_val;
  logic        issue_r1_dep, issue_r2_dep;
  logic [3:0]  issue_r1_rob, issue_r2_rob, issue_rob_id;
  logic        rs_full;
  logic        alu_fi, lsb_fi;
  logic [3:0]  alu_rob_id, lsb_rob_id;
  logic [31:0] alu_res, lsb_res;
  logic        alu_input;
  logic [4:0]  arith_type;
  logic [31:0] r1_val, r2_val;
  logic [3:0]  inst_rob_id;

  always #5 clk_in = ~clk_in;

  alu_rs dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_type(issue_type),
    .issue_r1_val(issue_r1_val), .issue_r1_dep(issue_r1_dep), .issue_r1_rob(issue_r1_rob),
    .issue_r2_val(issue_r2_val), .issue_r2_dep(issue_r2_dep), .issue_r2_rob(issue_r2_rob),
    .issue_rob_id(issue_rob_id), .rs_full(rs_full),
    .alu_fi(alu_fi), .alu_rob_id(alu_rob_id), .alu_res(alu_res),
    .lsb_fi(lsb_fi), .lsb_rob_id(lsb_rob_id), .lsb_res(lsb_res),
    .alu_input(alu_input), .arith_type(arith_type), .r1_val(r1_val), .r2_val(r2_val),
    .inst_rob_id(inst_rob_id)
  );

  typedef struct {
    logic [4:0]  t;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rob;
  } exp_t;

  exp_t sb[$];
  int   nvec = 0;
  int   nmis = 0;
  logic last_rdy;

  // rdy_in as seen by the most recent edge: a new dispatch only happens on a ready edge.
  always @(posedge clk_in) last_rdy <= rdy_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each fresh dispatch against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (!rst_in && alu_input === 1'b1 && last_rdy === 1'b1) begin
        if (sb.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_dispatch: got rob %0d, expected no dispatch", inst_rob_id);
        end else begin
          e = sb.pop_front();
          check("disp_type", {27'd0, arith_type}, {27'd0, e.t});
          check("disp_r1",   r1_val, e.a);
          check("disp_r2",   r2_val, e.b);
          check("disp_rob",  {28'd0, inst_rob_id}, {28'd0, e.rob});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_issue(input logic [4:0] t,
                           input logic [31:0] a, input logic da, input logic [3:0] qa,
                           input logic [31:0] b, input logic db, input logic [3:0] qb,
                           input logic [3:0] rob);
    issue_valid  = 1'b1;
    issue_type   = t;
    issue_r1_val = a;  issue_r1_dep = da; issue_r1_rob = qa;
    issue_r2_val = b;  issue_r2_dep = db; issue_r2_rob = qb;
    issue_rob_id = rob;
  endtask

  task automatic expect_disp(input logic [4:0] t, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] rob);
    exp_t e;
    e.t = t; e.a = a; e.b = b; e.rob = rob;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0; issue_valid = 1'b0;
    issue_type = '0; issue_r1_val = '0; issue_r1_dep = 1'b0; issue_r1_rob = '0;
    issue_r2_val = '0; issue_r2_dep = 1'b0; issue_r2_rob = '0; issue_rob_id = '0;
    alu_fi = 1'b0; alu_rob_id = '0; alu_res = '0;
    lsb_fi = 1'b0; lsb_rob_id = '0; lsb_res = '0;
    repeat (2) step();
    check("rst_alu_input", alu_input, 0);
    check("rst_type", arith_type, 0);
    check("rst_r1", r1_val, 0);
    check("rst_r2", r2_val, 0);
    check("rst_rob", inst_rob_id, 0);
    check("rst_full", rs_full, 0);
    rst_in = 1'b0;
    step();

    // 1: ready ADD dispatches one cycle after issue, then alu_input drops
    set_issue(5'b00000, 32'd5, 0, 0, 32'd7, 0, 0, 4'd3);
    expect_disp(5'b00000, 32'd5, 32'd7, 4'd3);
    step();
    issue_valid = 1'b0;
    check("t1_not_yet", alu_input, 0);
    step();
    check("t1_disp", alu_input, 1);
    step();
    check("t1_drop", alu_input, 0);
    check("t1_rob_zero", inst_rob_id, 0);

    // 2: src1 waits on rob 2, woken by ALU broadcast two cycles later
    set_issue(5'b00001, 32'd0, 1, 4'd2, 32'd3, 0, 0, 4'd4);
    step();
    issue_valid = 1'b0;
    step();
    alu_fi = 1'b1; alu_rob_id = 4'd2; alu_res = 32'h10;
    step();
    alu_fi = 1'b0;
    check("t2_no_early", alu_input, 0);
    expect_disp(5'b00001, 32'h10, 32'd3, 4'd4);
    step();
    check("t2_disp", alu_input, 1);
    drain(4);

    // 3: LSB broadcast captured in the issue cycle
    lsb_fi = 1'b1; lsb_rob_id = 4'd6; lsb_res = 32'd9;
    set_issue(5'b00100, 32'd0, 1, 4'd6, 32'd1, 0, 0, 4'd5);
    expect_disp(5'b00100, 32'd9, 32'd1, 4'd5);
    step();
    issue_valid = 1'b0; lsb_fi = 1'b0;
    drain(4);

    // 3b: both broadcasts match at issue; the ALU value is taken
    alu_fi = 1'b1; alu_rob_id = 4'd7; alu_res = 32'hAA;
    lsb_fi = 1'b1; lsb_rob_id = 4'd7; lsb_res = 32'hBB;
    set_issue(5'b00110, 32'h20, 0, 0, 32'd0, 1, 4'd7, 4'd6);
    expect_disp(5'b00110, 32'h20, 32'hAA, 4'd6);
    step();
    issue_valid = 1'b0; alu_fi = 1'b0; lsb_fi = 1'b0;
    drain(4);

    // 4: fill all 8 slots on rob 1, drop a 9th, then release them in index order
    for (int i = 0; i < 8; i++) begin
      set_issue(5'b10000, 32'd0, 1, 4'd1, i, 0, 0, 4'(8 + i));
      step();
    end
    issue_valid = 1'b0;
    check("t4_full", rs_full, 1);
    set_issue(5'b00000, 32'hDEAD, 0, 0, 32'hBEEF, 0, 0, 4'd0);
    step();
    issue_valid = 1'b0;
    check("t4_still_full", rs_full, 1);
    check("t4_no_disp", alu_input, 0);
    alu_fi = 1'b1; alu_rob_id = 4'd1; alu_res = 32'h77;
    for (int i = 0; i < 8; i++) expect_disp(5'b10000, 32'h77, i, 4'(8 + i));
    step();
    alu_fi = 1'b0;
    step();
    check("t4_full_drops", rs_full, 0);
    repeat (8) step();
    check("t4_consecutive", sb.size(), 0);
    repeat (3) step();
    check("t4_idle", alu_input, 0);

    // 5: four woken entries flushed by clear before any dispatch
    for (int i = 0; i < 4; i++) begin
      set_issue(5'b00010, 32'h100 + i, 1, 4'd2, 32'd0, 0, 0, 4'(i));
      step();
    end
    issue_valid = 1'b0;
    alu_fi = 1'b1; alu_rob_id = 4'd2; alu_res = 32'h55;
    step();
    alu_fi = 1'b0;
    check("t5_pre_clear", rs_full, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("t5_clear_alu_input", alu_input, 0);
    check("t5_clear_full", rs_full, 0);
    repeat (5) step();
    check("t5_no_dispatch", alu_input, 0);

    // 6: stall with a dispatch on the outputs; issue and broadcast ignored while stalled
    set_issue(5'b00011, 32'h11, 0, 0, 32'h22, 0, 0, 4'd9);
    expect_disp(5'b00011, 32'h11, 32'h22, 4'd9);
    step();
    set_issue(5'b00011, 32'h33, 0, 0, 32'h44, 0, 0, 4'd10);
    expect_disp(5'b00011, 32'h33, 32'h44, 4'd10);
    step();
    rdy_in = 1'b0;
    set_issue(5'b00111, 32'd1, 0, 0, 32'd2, 0, 0, 4'd14);
    alu_fi = 1'b1; alu_rob_id = 4'd0; alu_res = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_hold_valid", alu_input, 1);
      check("t6_hold_rob", inst_rob_id, 9);
    end
    rdy_in = 1'b1; issue_valid = 1'b0; alu_fi = 1'b0;
    step();
    check("t6_resume_rob", inst_rob_id, 10);
    step();
    check("t6_idle", alu_input, 0);
    drain(4);

    // 6b: asynchronous reset while an op is on the outputs and another is resident
    set_issue(5'b00001, 32'hA, 0, 0, 32'hB, 0, 0, 4'd11);
    expect_disp(5'b00001, 32'hA, 32'hB, 4'd11);
    step();
    set_issue(5'b00001, 32'hC, 0, 0, 32'hD, 0, 0, 4'd12);
    step();
    issue_valid = 1'b0;
    check("t6b_pre_reset", alu_input, 1);
    @(negedge clk_in);
    #1;
    rst_in = 1'b1;
    #1;
    check("t6b_rst_valid", alu_input, 0);
    check("t6b_rst_type", arith_type, 0);
    check("t6b_rst_r1", r1_val, 0);
    check("t6b_rst_r2", r2_val, 0);
    check("t6b_rst_rob", inst_rob_id, 0);
    check("t6b_rst_full", rs_full, 0);
    step();
    rst_in = 1'b0;
    repeat (4) step();
    check("t6b_entry_lost", alu_input, 0);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
